alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 45 ++++
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Handshake and ALU bus bundle for alu_arbiter: two requesters, the shared ALU,
// and the response channel. The slave side belongs to the arbiter.
interface alu_arbiter_if;
  logic       req0_valid;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [2:0] req0_op;
  logic       req0_ready;

  logic       req1_valid;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [2:0] req1_op;
  logic       req1_ready;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;

  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_ready;

  logic       busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared registered ALU: grants one request at a
// time (round-robin or fixed priority), issues it, and holds the response.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state_q;
  logic       ptr_q;
  logic       id_q;
  logic       rsp_valid_q;
  logic       busy_q;
  logic [3:0] alu_a_q;
  logic [3:0] alu_b_q;
  logic [2:0] alu_sel_q;
  logic [7:0] rsp_data_q;

  logic       gnt_id_d;
  logic       accept_d;
  logic       ptr_d;
  logic [3:0] a_d;
  logic [3:0] b_d;
  logic [2:0] op_d;

  // Grant: a lone requester always wins; on contention the pointer (or req0) decides.
  always_comb begin
    gnt_id_d = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id_d = RR_EN ? ptr_q : 1'b0;
    end else begin
      gnt_id_d = bus.req1_valid;
    end
    accept_d = rst_n && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
    ptr_d    = ~gnt_id_d;
    a_d      = gnt_id_d ? bus.req1_a  : bus.req0_a;
    b_d      = gnt_id_d ? bus.req1_b  : bus.req0_b;
    op_d     = gnt_id_d ? bus.req1_op : bus.req0_op;
  end

  assign bus.req0_ready = accept_d && !gnt_id_d;
  assign bus.req1_ready = accept_d &&  gnt_id_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      alu_a_q     <= 4'd0;
      alu_b_q     <= 4'd0;
      alu_sel_q   <= 3'd0;
      rsp_data_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            alu_a_q   <= a_d;
            alu_b_q   <= b_d;
            alu_sel_q <= op_d;
            id_q      <= gnt_id_d;
            ptr_q     <= ptr_d;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        // The ALU registered its result on the ISSUE edge; it is valid now.
        WAIT: begin
          rsp_data_q  <= bus.alu_result;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus;
// a transaction-level model (busy flag, pointer, result queue) predicts the RR instance.
module tb_alu_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if bus_rr ();
  alu_arbiter_if bus_fp ();

  alu_arbiter #(.RR_EN(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
  alu_arbiter #(.RR_EN(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

  assign bus_fp.req0_valid = bus_rr.req0_valid;
  assign bus_fp.req0_a     = bus_rr.req0_a;
  assign bus_fp.req0_b     = bus_rr.req0_b;
  assign bus_fp.req0_op    = bus_rr.req0_op;
  assign bus_fp.req1_valid = bus_rr.req1_valid;
  assign bus_fp.req1_a     = bus_rr.req1_a;
  assign bus_fp.req1_b     = bus_rr.req1_b;
  assign bus_fp.req1_op    = bus_rr.req1_op;
  assign bus_fp.rsp_ready  = bus_rr.rsp_ready;

  int n_run  = 0;
  int n_fail = 0;

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [7:0] xa;
    logic [7:0] xb;
    xa = {4'b0, a};
    xb = {4'b0, b};
    case (op)
      3'd0: return xa + xb;
      3'd1: return xa - xb;
      3'd2: return xa & xb;
      3'd3: return xa | xb;
      3'd4: return xa ^ xb;
      3'd5: return {4'b0, ~a};
      3'd6: return xa * xb;
      default: return (b == 4'd0) ? 8'h00 : xa / xb;
    endcase
  endfunction

  // Shared ALU models: one-cycle registered result.
  always @(posedge clk) begin
    bus_rr.alu_result <= alu_f(bus_rr.alu_a, bus_rr.alu_b, bus_rr.alu_sel);
    bus_fp.alu_result <= alu_f(bus_fp.alu_a, bus_fp.alu_b, bus_fp.alu_sel);
  end

  // Reference model of the round-robin instance.
  bit          m_busy = 1'b0;
  bit          m_ptr  = 1'b0;
  int          m_age  = 0;
  logic [10:0] m_last = 11'd0;
  logic [8:0]  m_q[$];

  function automatic logic [1:0] exp_rdy();
    logic g;
    if (m_busy || !rst_n || !(bus_rr.req0_valid || bus_rr.req1_valid)) return 2'b00;
    g = (bus_rr.req0_valid && bus_rr.req1_valid) ? m_ptr : bus_rr.req1_valid;
    return g ? 2'b10 : 2'b01;
  endfunction

  function automatic logic exp_rv();
    return m_busy && (m_age >= 3);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [1:0] r;
    logic       g;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr  = 1'b0;
      m_age  = 0;
      m_last = 11'd0;
      m_q.delete();
    end else begin
      r = exp_rdy();
      if (m_busy) begin
        if (m_age >= 3 && bus_rr.rsp_ready) begin
          void'(m_q.pop_front());
          m_busy = 1'b0;
        end else if (m_age < 3) begin
          m_age++;
        end
      end else if (r != 2'b00) begin
        g  = r[1];
        a  = g ? bus_rr.req1_a  : bus_rr.req0_a;
        b  = g ? bus_rr.req1_b  : bus_rr.req0_b;
        op = g ? bus_rr.req1_op : bus_rr.req0_op;
        m_q.push_back({g, alu_f(a, b, op)});
        m_last = {a, b, op};
        m_busy = 1'b1;
        m_age  = 1;
        m_ptr  = !g;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    bus_rr.req0_valid = 1'b0;
    bus_rr.req1_valid = 1'b0;
    bus_rr.rsp_ready  = 1'b1;
    k = 0;
    while ((bus_rr.busy || bus_fp.busy) && k < 12) begin
      tick();
      k++;
    end
    n_run++;
    if (bus_rr.busy || bus_fp.busy) begin
      n_fail++;
      $display("FAIL drain_idle: busy rr/fp=%b%b after %0d cycles, want 00", bus_rr.busy, bus_fp.busy, k);
    end
  endtask

  task automatic test_reset();
    bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 4'd3; bus_rr.req0_b = 4'd5; bus_rr.req0_op = 3'd0;
    bus_rr.req1_valid = 1'b1; bus_rr.req1_a = 4'd1; bus_rr.req1_b = 4'd1; bus_rr.req1_op = 3'd0;
    bus_rr.rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_run++;
    if ({bus_rr.req0_ready, bus_rr.req1_ready, bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_data,
         bus_rr.alu_a, bus_rr.alu_b, bus_rr.alu_sel, bus_rr.busy} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_rr_outputs: got rdy=%b%b rv=%b id=%b d=%h a=%h b=%h s=%h busy=%b, want all 0",
               bus_rr.req0_ready, bus_rr.req1_ready, bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_data,
               bus_rr.alu_a, bus_rr.alu_b, bus_rr.alu_sel, bus_rr.busy);
    end
    n_run++;
    if ({bus_fp.req0_ready, bus_fp.req1_ready, bus_fp.rsp_valid, bus_fp.rsp_id, bus_fp.rsp_data,
         bus_fp.busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_fp_outputs: got rdy=%b%b rv=%b busy=%b, want 0", bus_fp.req0_ready,
               bus_fp.req1_ready, bus_fp.rsp_valid, bus_fp.busy);
    end
    bus_rr.req1_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    n_run++;
    if (bus_rr.req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL first_edge_ready: got %b, want 1", bus_rr.req0_ready);
    end
    tick();
    bus_rr.req0_valid = 1'b0;
    n_run++;
    if ({bus_rr.busy, bus_rr.alu_a, bus_rr.alu_b, bus_rr.alu_sel} !== {1'b1, 4'd3, 4'd5, 3'd0}) begin
      n_fail++;
      $display("FAIL first_edge_accept: got busy=%b a=%h b=%h s=%h, want 1 3 5 0",
               bus_rr.busy, bus_rr.alu_a, bus_rr.alu_b, bus_rr.alu_sel);
    end
    wait_idle();
  endtask

  task automatic test_single();
    wait_idle();
    tick();
    bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 4'd3; bus_rr.req0_b = 4'd5; bus_rr.req0_op = 3'd0;
    @(negedge clk);
    n_run++;
    if ({bus_rr.req1_ready, bus_rr.req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_grant: got r1r0=%b%b, want 01", bus_rr.req1_ready, bus_rr.req0_ready);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 3) bus_rr.req0_valid = 1'b0;
      @(negedge clk);
      n_run++;
      if (bus_rr.rsp_valid !== (c == 3) || bus_rr.req0_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL single_timing c%0d: got rv=%b rdy0=%b, want rv=%b rdy0=0", c,
                 bus_rr.rsp_valid, bus_rr.req0_ready, (c == 3));
      end
      if (c == 1) begin
        n_run++;
        if ({bus_rr.alu_a, bus_rr.alu_b, bus_rr.alu_sel} !== {4'd3, 4'd5, 3'd0}) begin
          n_fail++;
          $display("FAIL single_issue: got a=%h b=%h s=%h, want 3 5 0", bus_rr.alu_a, bus_rr.alu_b, bus_rr.alu_sel);
        end
      end
      if (c == 3) begin
        n_run++;
        if ({bus_rr.rsp_id, bus_rr.rsp_data} !== {1'b0, 8'h08}) begin
          n_fail++;
          $display("FAIL single_rsp: got id=%b d=%h, want 0 08", bus_rr.rsp_id, bus_rr.rsp_data);
        end
      end
    end
  endtask

  task automatic test_div0();
    int lat;
    wait_idle();
    tick();
    bus_rr.req1_valid = 1'b1; bus_rr.req1_a = 4'd7; bus_rr.req1_b = 4'd0; bus_rr.req1_op = 3'd7;
    @(negedge clk);
    n_run++;
    if ({bus_rr.req1_ready, bus_rr.req0_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL div0_grant: got r1r0=%b%b, want 10", bus_rr.req1_ready, bus_rr.req0_ready);
    end
    tick();
    bus_rr.req1_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus_rr.rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_run++;
    if (lat != 3 || {bus_rr.rsp_id, bus_rr.rsp_data} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL div0_rsp: got lat=%0d id=%b d=%h, want 3 1 00", lat, bus_rr.rsp_id, bus_rr.rsp_data);
    end
  endtask

  task automatic test_rr();
    logic [8:0] got[$];
    logic [8:0] want;
    wait_idle();
    tick();
    bus_rr.req0_a = 4'd4; bus_rr.req0_b = 4'd3; bus_rr.req0_op = 3'd6;
    bus_rr.req1_a = 4'd9; bus_rr.req1_b = 4'd2; bus_rr.req1_op = 3'd1;
    bus_rr.req0_valid = 1'b1;
    bus_rr.req1_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_run++;
      if ({bus_rr.req1_ready, bus_rr.req0_ready} !== exp_rdy() || bus_rr.rsp_valid !== exp_rv()) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: got r1r0=%b%b rv=%b, want %b %b", c, bus_rr.req1_ready,
                 bus_rr.req0_ready, bus_rr.rsp_valid, exp_rdy(), exp_rv());
      end
      if (bus_rr.rsp_valid === 1'b1) got.push_back({bus_rr.rsp_id, bus_rr.rsp_data});
    end
    n_run++;
    if (got.size() < 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d responses, want at least 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      want = (i % 2 == 0) ? {1'b0, 8'h0C} : {1'b1, 8'h07};
      n_run++;
      if (got[i] !== want) begin
        n_fail++;
        $display("FAIL rr_order%0d: got id=%b d=%h, want id=%b d=%h", i, got[i][8], got[i][7:0], want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_fixed();
    int cnt;
    cnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      n_run++;
      if (bus_fp.req1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL fp_req1_ready c%0d: got %b, want 0", c, bus_fp.req1_ready);
      end
      if (bus_fp.rsp_valid === 1'b1) begin
        cnt++;
        n_run++;
        if ({bus_fp.rsp_id, bus_fp.rsp_data} !== {1'b0, 8'h0C}) begin
          n_fail++;
          $display("FAIL fp_rsp: got id=%b d=%h, want 0 0c", bus_fp.rsp_id, bus_fp.rsp_data);
        end
      end
    end
    n_run++;
    if (cnt < 4) begin
      n_fail++;
      $display("FAIL fp_count: got %0d responses, want at least 4", cnt);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    wait_idle();
    tick();
    bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 4'd2; bus_rr.req0_b = 4'd3; bus_rr.req0_op = 3'd2;
    bus_rr.req1_valid = 1'b0;
    bus_rr.rsp_ready  = 1'b0;
    tick();
    bus_rr.req1_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      seen = (bus_rr.rsp_valid === 1'b1);
    end
    n_run++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bp_arrive: got no rsp_valid within 6 cycles, want one");
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_run++;
      if ({bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_data, bus_rr.req0_ready, bus_rr.req1_ready}
          !== {1'b1, 1'b0, 8'h02, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: got rv=%b id=%b d=%h rdy=%b%b, want 1 0 02 00", c, bus_rr.rsp_valid,
                 bus_rr.rsp_id, bus_rr.rsp_data, bus_rr.req0_ready, bus_rr.req1_ready);
      end
    end
    tick();
    bus_rr.req0_valid = 1'b0;
    bus_rr.req1_valid = 1'b0;
    bus_rr.rsp_ready  = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_run++;
      if (bus_rr.rsp_valid !== 1'b0 || bus_rr.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_release c%0d: got rv=%b busy=%b, want 0 0", c, bus_rr.rsp_valid, bus_rr.busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_idle();
    tick();
    bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 4'd15; bus_rr.req0_b = 4'd15; bus_rr.req0_op = 3'd6;
    tick();
    bus_rr.req0_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if ({bus_rr.req0_ready, bus_rr.req1_ready, bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_data,
         bus_rr.alu_a, bus_rr.alu_b, bus_rr.alu_sel, bus_rr.busy} !== 24'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rv=%b d=%h a=%h b=%h s=%h busy=%b, want all 0", bus_rr.rsp_valid,
               bus_rr.rsp_data, bus_rr.alu_a, bus_rr.alu_b, bus_rr.alu_sel, bus_rr.busy);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_run++;
      if (bus_rr.rsp_valid !== 1'b0 || bus_rr.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_after c%0d: got rv=%b busy=%b, want 0 0", c, bus_rr.rsp_valid, bus_rr.busy);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick();
      bus_rr.req0_valid = ($urandom % 4) != 0;
      bus_rr.req1_valid = ($urandom % 3) != 0;
      bus_rr.req0_a  = 4'($urandom); bus_rr.req0_b  = 4'($urandom); bus_rr.req0_op = 3'($urandom);
      bus_rr.req1_a  = 4'($urandom); bus_rr.req1_b  = 4'($urandom); bus_rr.req1_op = 3'($urandom);
      bus_rr.rsp_ready = ($urandom % 3) != 0;
      @(negedge clk);
      n_run++;
      if ({bus_rr.req1_ready, bus_rr.req0_ready} !== exp_rdy() || bus_rr.rsp_valid !== exp_rv() ||
          bus_rr.busy !== m_busy || {bus_rr.alu_a, bus_rr.alu_b, bus_rr.alu_sel} !== m_last) begin
        n_fail++;
        $display("FAIL rand_ctrl c%0d: got r1r0=%b%b rv=%b busy=%b alu=%h, want %b %b %b %h", c,
                 bus_rr.req1_ready, bus_rr.req0_ready, bus_rr.rsp_valid, bus_rr.busy,
                 {bus_rr.alu_a, bus_rr.alu_b, bus_rr.alu_sel}, exp_rdy(), exp_rv(), m_busy, m_last);
      end
      if (exp_rv()) begin
        n_run++;
        if ({bus_rr.rsp_id, bus_rr.rsp_data} !== m_q[0]) begin
          n_fail++;
          $display("FAIL rand_rsp c%0d: got id=%b d=%h, want id=%b d=%h", c, bus_rr.rsp_id,
                   bus_rr.rsp_data, m_q[0][8], m_q[0][7:0]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_run);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_rr.req0_valid = 1'b0; bus_rr.req0_a = 4'd0; bus_rr.req0_b = 4'd0; bus_rr.req0_op = 3'd0;
    bus_rr.req1_valid = 1'b0; bus_rr.req1_a = 4'd0; bus_rr.req1_b = 4'd0; bus_rr.req1_op = 3'd0;
    bus_rr.rsp_ready  = 1'b1;
    test_reset();
    test_single();
    test_div0();
    test_rr();
    test_fixed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
